instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch front-end sitting directly upstream of the single-cycle MIPS datapath.
- Issues sequential word fetches to an instruction memory over a request/response handshake, and buffers returned words with their PCs in a small FIFO.
- Delivers {pc, instruction} pairs to the decode/execute stage over valid/ready.
- On a jump, branch or jalfor redirect, flushes its buffer and discards in-flight stale responses.

Parameters:
- DEPTH, 4: FIFO entries, power of two, ≥2.
- MAX_OUTSTANDING, 2: maximum unanswered imem requests, 1..DEPTH.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous assert, active-low (0 = reset)
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  byte address, word aligned
- imem_resp_valid  in  1  response word valid; in order, no back-pressure
- imem_resp_data  in  32  instruction word
- instr_valid  out  1  head entry valid toward datapath
- instr_ready  in  1  datapath consumes head entry
- instr_data  out  32  head instruction
- instr_pc  out  32  PC of head instruction
- queue_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=0):
  - state=BOOT; fetch_pc=RESET_PC; FIFO empty.
  - outstanding=0; drop_cnt=0.
  - All outputs 0, except imem_req_addr=RESET_PC.
- States:
  - BOOT → RUN after one cycle.
  - RUN → FLUSH on redirect_valid when stale requests remain in flight.
  - FLUSH → RUN when drop_cnt reaches 0.
  - Redirect with nothing in flight goes to RUN directly.
- Issue rule:
  - imem_req_valid = (state==RUN) && !redirect_valid && outstanding<MAX_OUTSTANDING && (queue_count+outstanding)<DEPTH.
  - imem_req_addr = fetch_pc.
  - Request handshake (valid&&ready): fetch_pc += 4 (mod 2^32, wraps silently); outstanding++.
- Response rule, each imem_resp_valid:
  - outstanding--.
  - If drop_cnt>0: drop_cnt--, word discarded.
  - Otherwise push {resp_pc, imem_resp_data}. resp_pc comes from an internal PC-of-oldest-in-flight register, incremented by 4 per non-dropped response.
  - Credit rule guarantees the FIFO is never full on push; a push to a full FIFO is a design error and must be asserted against.
- Output:
  - instr_valid = (queue_count!=0) && state!=BOOT; instr_data/instr_pc = head entry (registered storage, combinational read).
  - Pop on instr_valid&&instr_ready.
  - Push and pop in the same cycle leave queue_count unchanged.
- Latency: first request one cycle after reset release. With zero-latency memory (resp the cycle after accept) the first instr_valid appears 3 cycles after reset release; sustained throughput is 1 instruction/cycle when MAX_OUTSTANDING≥2.
- Redirect (highest priority, takes effect at the clock edge):
  - FIFO cleared; pop in the same cycle ignored.
  - fetch_pc and resp_pc set to {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is itself dropped.
  - No request issues in the redirect cycle.
- Redirect while in FLUSH: drop_cnt recomputed as above (accumulates correctly because outstanding still counts the stale requests). Stays in FLUSH if the result is >0.
- Reset mid-operation: immediate return to reset values. Responses to pre-reset requests are the memory's responsibility to suppress.
- No X on any output after reset, including when the FIFO is empty (instr_data/pc hold last or 0).

Decomposition:
- Package mips_fetch_pkg:
  - INSTR_W=32, ADDR_W=32, PC_STEP=4.
  - fetch_state_t enum {BOOT, RUN, FLUSH}.
  - fetch_entry_t struct {pc, data}.
- One sub-module: fetch_fifo.
  - Synchronous FIFO parameterised by DEPTH and width.
  - Ports push/pop/flush/count/head; same clock and reset.
  - Pointer wrap via extra MSB.

Test Plan:
- Reset release, memory always ready, 1-cycle response, instr_ready=1 → imem_req_addr 0,4,8,… on consecutive cycles; instr_pc 0,4,8 with matching data; 1 instr/cycle sustained after fill.
- instr_ready held 0 → exactly DEPTH=4 entries buffered, imem_req_valid drops, queue_count=4. Release ready → pcs 0,4,8,12 in order, fetching resumes at 16.
- Two requests in flight (addr 0x10, 0x14) then redirect_pc=0x40 → both stale responses dropped, state FLUSH for 2 responses, next instr_pc=0x40.
- Redirect in the same cycle as a response and a pop → FIFO empty next cycle, that response dropped, drop_cnt=outstanding−1, no request issued that cycle.
- redirect_pc=0xFFFF_FFFE → first fetch 0xFFFF_FFFC, next 0x0000_0000 (wrap).
- rst pulsed low mid-stream with FIFO half full → all outputs 0 asynchronously, restart fetch at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch front-end.
package mips_fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] data;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head read.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] entry_view [DEPTH];
  logic         full;
  logic         empty;
  logic         do_push;
  logic         do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = entry_view[rd_ptr_q[AW-1:0]];

  // Flushing collapses the write pointer onto the read pointer so the head keeps its last value.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        entry_q <= '0;
      end else if (do_push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
        entry_q <= push_data;
      end
    end
    assign entry_view[gi] = entry_q;
  end

  // The upstream credit scheme must never let a push meet a full buffer.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst) !(push && full && !flush));

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with credit-limited requests, a PC-tagged buffer and redirect flush.
module instr_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDR_W-1:0]        imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [INSTR_W-1:0]       imem_resp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [INSTR_W-1:0]       instr_data,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(DEPTH);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic [ADDR_W-1:0]  redirect_aligned;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic               req_fire;
  logic               resp_drop;
  logic               fifo_push;
  logic               fifo_pop;

  // Buffered plus in-flight words may never exceed the buffer size, so a response always has room.
  assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid   = (state_q == RUN) && !redirect_valid &&
                            (outstanding_q < MAX_OUT_C) && (credit_used < DEPTH_C);
  assign imem_req_addr    = fetch_pc_q;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign resp_drop        = imem_resp_valid && (drop_cnt_q != '0);
  assign redirect_aligned = word_align(redirect_pc);

  assign push_entry  = '{pc: resp_pc_q, data: imem_resp_data};
  assign fifo_push   = imem_resp_valid && !resp_drop && !redirect_valid;
  assign instr_valid = (fifo_count != '0) && (state_q != BOOT);
  assign fifo_pop    = instr_valid && instr_ready && !redirect_valid;
  assign instr_data  = head_entry.data;
  assign instr_pc    = head_entry.pc;
  assign queue_count = fifo_count;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + PC_STEP;
      outstanding_d = outstanding_d + 1'b1;
    end
    if (imem_resp_valid) begin
      outstanding_d = outstanding_d - 1'b1;
    end
    if (resp_drop) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end else if (imem_resp_valid) begin
      resp_pc_d = resp_pc_q + PC_STEP;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Every request still in flight is stale; the one answering right now is already discarded.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = outstanding_q - CNT_W'(imem_resp_valid);
      state_d    = (drop_cnt_d != '0) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (head_entry)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a one-cycle in-order memory model.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [2:0]  queue_count;

  logic        resp_hold;
  logic [31:0] mem_q [$];
  int          n_vec;
  int          n_miss;

  instr_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .queue_count     (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: accepts on the handshake, answers in order one cycle later unless held.
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) mem_q.delete();
      else if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
      @(posedge clk);
      #2;
      if (rst && !resp_hold && mem_q.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_q.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Returns one time unit after the edge that precedes the first post-reset clock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resp_hold      = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pops(input logic [31:0] first_pc, input int n, input int budget);
    logic [31:0] pc;
    int          got;
    pc  = first_pc;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        $display("pop pc=%h data=%h count=%0d", instr_pc, instr_data, queue_count);
        chk("pop_pc", {32'd0, instr_pc}, {32'd0, pc});
        chk("pop_data", {32'd0, instr_data}, {32'd0, mem_word(pc)});
        pc  = pc + 32'd4;
        got++;
      end
    end
    chk("pop_count", 64'(got), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    resp_hold      = 1'b0;
    instr_ready    = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'h0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr_data", 64'(instr_data), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);

    // Streaming with an always-ready consumer
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("s_boot_req", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    chk("s_first_req", 64'(imem_req_valid), 64'd1);
    chk("s_first_addr", 64'(imem_req_addr), 64'h0);
    chk("s_no_instr1", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("s_addr4", 64'(imem_req_addr), 64'h4);
    chk("s_no_instr2", 64'(instr_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      $display("stream k=%0d pc=%h addr=%h count=%0d", k, instr_pc, imem_req_addr, queue_count);
      chk("s_valid", 64'(instr_valid), 64'd1);
      chk("s_pc", 64'(instr_pc), 64'(4 * k));
      chk("s_data", 64'(instr_data), 64'(mem_word(32'(4 * k))));
      chk("s_addr", 64'(imem_req_addr), 64'(4 * k + 8));
      chk("s_count", 64'(queue_count), 64'd1);
    end

    // Consumer stalled: buffer fills to four entries and fetching stops
    do_reset();
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("f_req_stop", 64'(imem_req_valid), 64'd0);
    @(negedge clk);
    chk("f_count_full", 64'(queue_count), 64'd4);
    chk("f_req_off", 64'(imem_req_valid), 64'd0);
    chk("f_head_pc", 64'(instr_pc), 64'h0);
    next_cycle();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("f_head_pc0", 64'(instr_pc), 64'h0);
    chk("f_count_still", 64'(queue_count), 64'd4);
    @(negedge clk);
    chk("f_head_pc4", 64'(instr_pc), 64'h4);
    chk("f_count3", 64'(queue_count), 64'd3);
    chk("f_resume_req", 64'(imem_req_valid), 64'd1);
    chk("f_resume_addr", 64'(imem_req_addr), 64'h10);
    expect_pops(32'h8, 4, 20);

    // Redirect with two stale requests in flight
    do_reset();
    instr_ready = 1'b1;
    resp_hold   = 1'b1;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("r_addr10", 64'(imem_req_addr), 64'h10);
    @(negedge clk);
    chk("r_addr14", 64'(imem_req_addr), 64'h14);
    chk("r_req14", 64'(imem_req_valid), 64'd1);
    @(negedge clk);
    chk("r_out_limit", 64'(imem_req_valid), 64'd0);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    chk("r_redir_noreq", 64'(imem_req_valid), 64'd0);
    next_cycle();
    redirect_valid = 1'b0;
    resp_hold      = 1'b0;
    @(negedge clk);
    chk("r_flush_req1", 64'(imem_req_valid), 64'd0);
    chk("r_flush_empty", 64'(queue_count), 64'd0);
    @(negedge clk);
    chk("r_flush_req2", 64'(imem_req_valid), 64'd0);
    chk("r_flush_novalid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    chk("r_restart_req", 64'(imem_req_valid), 64'd1);
    chk("r_restart_addr", 64'(imem_req_addr), 64'h40);
    expect_pops(32'h40, 3, 20);

    // Redirect coinciding with a response and a pop
    do_reset();
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    chk("c_noreq", 64'(imem_req_valid), 64'd0);
    chk("c_resp_present", 64'(imem_resp_valid), 64'd1);
    chk("c_pop_attempt", 64'(instr_valid), 64'd1);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("c_empty", 64'(queue_count), 64'd0);
    chk("c_novalid", 64'(instr_valid), 64'd0);
    chk("c_req_run", 64'(imem_req_valid), 64'd1);
    chk("c_addr", 64'(imem_req_addr), 64'h100);
    expect_pops(32'h100, 3, 20);

    // Unaligned redirect near the top of the address space wraps to zero
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("w_addr_top", 64'(imem_req_addr), 64'hFFFF_FFFC);
    chk("w_req", 64'(imem_req_valid), 64'd1);
    @(negedge clk);
    chk("w_addr_wrap", 64'(imem_req_addr), 64'h0);
    expect_pops(32'hFFFF_FFFC, 3, 20);

    // Asynchronous reset with the buffer half full
    do_reset();
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_count2", 64'(queue_count), 64'd2);
    chk("a_data_pre", 64'(instr_data), 64'(mem_word(32'h0)));
    #1;
    rst = 1'b0;
    #1;
    chk("a_req_valid", 64'(imem_req_valid), 64'd0);
    chk("a_req_addr", 64'(imem_req_addr), 64'h0);
    chk("a_instr_valid", 64'(instr_valid), 64'd0);
    chk("a_instr_data", 64'(instr_data), 64'd0);
    chk("a_instr_pc", 64'(instr_pc), 64'd0);
    chk("a_count", 64'(queue_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("a_restart_req", 64'(imem_req_valid), 64'd1);
    chk("a_restart_addr", 64'(imem_req_addr), 64'h0);
    expect_pops(32'h0, 3, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
